// File: rtl/sid_bus_responder_if.sv
// SID register bus as seen at the chip pins: initiator-driven controls plus the read-data pad.
interface sid_bus_responder_if;
    logic       SID_CLK;
    logic       SID_NOTRES;
    logic       SID_NOTCS;
    logic       SID_RW;
    logic [4:0] SID_ADDR;
    logic [7:0] SID_DATA_IN;
    logic [7:0] SID_DATA_OUT;
    logic       SID_DATA_OE;

    // Initiator side: drives phase-2, select and write data, sees the read pad.
    modport master (
        output SID_CLK,
        output SID_NOTRES,
        output SID_NOTCS,
        output SID_RW,
        output SID_ADDR,
        output SID_DATA_IN,
        input  SID_DATA_OUT,
        input  SID_DATA_OE
    );

    // Chip side: samples the bus, drives the read pad.
    modport slave (
        input  SID_CLK,
        input  SID_NOTRES,
        input  SID_NOTCS,
        input  SID_RW,
        input  SID_ADDR,
        input  SID_DATA_IN,
        output SID_DATA_OUT,
        output SID_DATA_OE
    );
endinterface

// File: rtl/sid_bus_responder.sv
// sid_bus_responder: MOS6581-style register bus slave running on the 8 MHz system clock.
// Oversamples SID_CLK, commits writes to a register shadow plus a strobe stream, answers reads.
module sid_bus_responder #(
    parameter int unsigned SYNC_STAGES  = 2,
    parameter int unsigned DECAY_CYCLES = 2000
) (
    input  logic               C6_CLK_8MHZ,
    input  logic               SID_RESET,
    sid_bus_responder_if.slave bus,
    input  logic [7:0]         POTX,
    input  logic [7:0]         POTY,
    input  logic [7:0]         OSC3,
    input  logic [7:0]         ENV3,
    output logic               WR_STROBE,
    output logic [4:0]         WR_ADDR,
    output logic [7:0]         WR_DATA,
    input  logic [4:0]         SHD_ADDR,
    output logic [7:0]         SHD_DATA
);

    localparam int unsigned NUM_REGS = 29;
    localparam int unsigned SW       = 17;
    localparam int unsigned DW       = $clog2(DECAY_CYCLES + 1);

    localparam logic [4:0]    LAST_WR_ADDR = 5'h18;
    localparam logic [4:0]    ADDR_POTX    = 5'h19;
    localparam logic [4:0]    ADDR_POTY    = 5'h1A;
    localparam logic [4:0]    ADDR_OSC3    = 5'h1B;
    localparam logic [4:0]    ADDR_ENV3    = 5'h1C;
    localparam logic [DW-1:0] DECAY_MAX    = DW'(DECAY_CYCLES);

    typedef enum logic [1:0] {
        ST_RST  = 2'd0,
        ST_IDLE = 2'd1,
        ST_ACC  = 2'd2
    } state_e;

    // Synchronizer pipe and edge history
    logic [SW-1:0] pins_c;
    logic [SW-1:0] sync_q [SYNC_STAGES];
    logic [SW-1:0] bus_s;
    logic          clk_prev_q;

    logic          clk_s;
    logic          notres_s;
    logic          cs_n_s;
    logic          rw_s;
    logic [4:0]    addr_s;
    logic [7:0]    data_s;

    logic          rise_c;
    logic          fall_c;
    logic          bus_rst_c;

    // FSM
    state_e        state_q;
    state_e        state_d;
    logic          acc_start_c;
    logic          acc_end_c;
    logic          wr_commit_c;

    // Datapath
    logic          cap_rw_q;
    logic [4:0]    cap_addr_q;
    logic [7:0]    shadow_q [NUM_REGS];
    logic [7:0]    latch_q;
    logic [DW-1:0] decay_q;
    logic [7:0]    latch_eff_c;
    logic [7:0]    rd_val_c;
    logic          wr_strobe_q;
    logic [4:0]    wr_addr_q;
    logic [7:0]    wr_data_q;
    logic [7:0]    dout_q;
    logic          oe_q;
    logic [7:0]    shd_data_q;

    assign pins_c = {bus.SID_CLK, bus.SID_NOTRES, bus.SID_NOTCS, bus.SID_RW,
                     bus.SID_ADDR, bus.SID_DATA_IN};

    // All bus pins share one delay pipe so select/address/data stay aligned with SID_CLK.
    // Left unreset so edge history is continuous across reset and no false RISE appears on release.
    always_ff @(posedge C6_CLK_8MHZ) begin
        sync_q[0] <= pins_c;
        for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
            sync_q[i] <= sync_q[i-1];
        end
        clk_prev_q <= clk_s;
    end

    assign bus_s    = sync_q[SYNC_STAGES-1];
    assign clk_s    = bus_s[16];
    assign notres_s = bus_s[15];
    assign cs_n_s   = bus_s[14];
    assign rw_s     = bus_s[13];
    assign addr_s   = bus_s[12:8];
    assign data_s   = bus_s[7:0];

    assign rise_c    = clk_s & ~clk_prev_q;
    assign fall_c    = ~clk_s & clk_prev_q;
    assign bus_rst_c = ~notres_s;

    // FSM state register.
    always_ff @(posedge C6_CLK_8MHZ) begin
        if (SID_RESET) begin
            state_q <= ST_RST;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state and per-cycle access controls; bus reset overrides everything.
    always_comb begin
        state_d     = state_q;
        acc_start_c = 1'b0;
        acc_end_c   = 1'b0;
        wr_commit_c = 1'b0;
        case (state_q)
            ST_RST: begin
                state_d = ST_IDLE;
            end
            ST_IDLE: begin
                if (rise_c && !cs_n_s) begin
                    state_d     = ST_ACC;
                    acc_start_c = 1'b1;
                end
            end
            ST_ACC: begin
                if (fall_c) begin
                    state_d     = ST_IDLE;
                    acc_end_c   = 1'b1;
                    wr_commit_c = ~cap_rw_q;
                end
            end
            default: begin
                state_d = ST_RST;
            end
        endcase
        if (bus_rst_c) begin
            state_d     = ST_RST;
            acc_start_c = 1'b0;
            acc_end_c   = 1'b0;
            wr_commit_c = 1'b0;
        end
    end

    // Read mux: analog/voice registers are live inputs, everything else returns the decaying bus latch.
    always_comb begin
        latch_eff_c = (decay_q == DECAY_MAX) ? 8'h00 : latch_q;
        case (addr_s)
            ADDR_POTX: rd_val_c = POTX;
            ADDR_POTY: rd_val_c = POTY;
            ADDR_OSC3: rd_val_c = OSC3;
            ADDR_ENV3: rd_val_c = ENV3;
            default:   rd_val_c = latch_eff_c;
        endcase
    end

    // Access capture, write commit, read return, bus latch decay and shadow debug port.
    always_ff @(posedge C6_CLK_8MHZ) begin
        if (SID_RESET || bus_rst_c) begin
            cap_rw_q    <= 1'b1;
            cap_addr_q  <= 5'h00;
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                shadow_q[i] <= 8'h00;
            end
            latch_q     <= 8'h00;
            decay_q     <= '0;
            wr_strobe_q <= 1'b0;
            wr_addr_q   <= 5'h00;
            wr_data_q   <= 8'h00;
            dout_q      <= 8'h00;
            oe_q        <= 1'b0;
            shd_data_q  <= 8'h00;
        end else begin
            wr_strobe_q <= 1'b0;

            if (acc_start_c) begin
                cap_rw_q   <= rw_s;
                cap_addr_q <= addr_s;
                if (rw_s) begin
                    dout_q  <= rd_val_c;
                    latch_q <= rd_val_c;
                    oe_q    <= 1'b1;
                end
            end

            if (acc_end_c) begin
                oe_q <= 1'b0;
            end

            if (wr_commit_c) begin
                latch_q <= data_s;
                decay_q <= '0;
                if (cap_addr_q <= LAST_WR_ADDR) begin
                    shadow_q[cap_addr_q] <= data_s;
                    wr_addr_q            <= cap_addr_q;
                    wr_data_q            <= data_s;
                    wr_strobe_q          <= 1'b1;
                end
            end else if (fall_c && state_q != ST_RST && decay_q != DECAY_MAX) begin
                decay_q <= decay_q + DW'(1);
            end

            shd_data_q <= (SHD_ADDR < 5'(NUM_REGS)) ? shadow_q[SHD_ADDR] : 8'h00;
        end
    end

    assign bus.SID_DATA_OUT = dout_q;
    assign bus.SID_DATA_OE  = oe_q;
    assign WR_STROBE        = wr_strobe_q;
    assign WR_ADDR          = wr_addr_q;
    assign WR_DATA          = wr_data_q;
    assign SHD_DATA         = shd_data_q;

endmodule

// File: tb/tb_sid_bus_responder.sv
// Bench for sid_bus_responder: directed scenarios plus random bus traffic against a register-level model.
module tb_sid_bus_responder;

    localparam int unsigned SYNC  = 2;
    localparam int unsigned DECAY = 2000;

    logic       clk;
    logic       SID_RESET;
    logic [7:0] POTX, POTY, OSC3, ENV3;
    logic       WR_STROBE;
    logic [4:0] WR_ADDR;
    logic [7:0] WR_DATA;
    logic [4:0] SHD_ADDR;
    logic [7:0] SHD_DATA;

    sid_bus_responder_if bif ();

    sid_bus_responder #(
        .SYNC_STAGES  (SYNC),
        .DECAY_CYCLES (DECAY)
    ) dut (
        .C6_CLK_8MHZ (clk),
        .SID_RESET   (SID_RESET),
        .bus         (bif),
        .POTX        (POTX),
        .POTY        (POTY),
        .OSC3        (OSC3),
        .ENV3        (ENV3),
        .WR_STROBE   (WR_STROBE),
        .WR_ADDR     (WR_ADDR),
        .WR_DATA     (WR_DATA),
        .SHD_ADDR    (SHD_ADDR),
        .SHD_DATA    (SHD_DATA)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp;
    int n_err;
    int strobe_cnt;
    int oe_cnt;

    // Reference model: register file contents, bus latch value and periods since last write.
    logic [7:0] m_shadow [32];
    logic [7:0] m_latch;
    int         m_decay;
    logic [4:0] m_wa;
    logic [7:0] m_wd;
    logic [7:0] m_dout;

    // Count strobe cycles and OE cycles, sampled mid-cycle.
    always @(negedge clk) begin
        if (WR_STROBE === 1'b1) strobe_cnt++;
        if (bif.SID_DATA_OE === 1'b1) oe_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_shadow[i] = 8'h00;
        m_latch = 8'h00;
        m_decay = 0;
        m_wa    = 5'h00;
        m_wd    = 8'h00;
        m_dout  = 8'h00;
    endtask

    // One SID_CLK period: 4 system clocks high (new bus values), 4 low.
    task automatic bus_period(input logic cs_n, input logic rw, input logic [4:0] addr,
                              input logic [7:0] data, input bit glitch);
        @(negedge clk);
        bif.SID_NOTCS   = cs_n;
        bif.SID_RW      = rw;
        bif.SID_ADDR    = addr;
        bif.SID_DATA_IN = data;
        bif.SID_CLK     = 1'b1;
        repeat (2) @(negedge clk);
        if (glitch) begin
            bif.SID_RW   = ~rw;
            bif.SID_ADDR = ~addr;
        end
        repeat (2) @(negedge clk);
        bif.SID_CLK = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    // Drive one period, advance the model by the bus rules, then compare every visible effect.
    task automatic access(input string tag, input logic cs_n, input logic rw,
                          input logic [4:0] addr, input logic [7:0] data, input bit glitch);
        int         s0, o0;
        bit         is_rd, exp_stb;
        logic [7:0] rv;
        is_rd   = !cs_n && rw;
        exp_stb = 1'b0;
        if (is_rd) begin
            case (addr)
                5'h19:   rv = POTX;
                5'h1A:   rv = POTY;
                5'h1B:   rv = OSC3;
                5'h1C:   rv = ENV3;
                default: rv = (m_decay >= int'(DECAY)) ? 8'h00 : m_latch;
            endcase
            m_latch = rv;
            m_dout  = rv;
        end
        if (!cs_n && !rw) begin
            m_latch = data;
            m_decay = 0;
            if (addr <= 5'h18) begin
                m_shadow[addr] = data;
                m_wa    = addr;
                m_wd    = data;
                exp_stb = 1'b1;
            end
        end else if (m_decay < int'(DECAY)) begin
            m_decay++;
        end
        s0 = strobe_cnt;
        o0 = oe_cnt;
        bus_period(cs_n, rw, addr, data, glitch);
        chk({tag, "/strobes"}, 32'(strobe_cnt - s0), 32'(exp_stb));
        chk({tag, "/oe_cycles"}, 32'(oe_cnt - o0), is_rd ? 32'd4 : 32'd0);
        chk({tag, "/wr_addr"}, 32'(WR_ADDR), 32'(m_wa));
        chk({tag, "/wr_data"}, 32'(WR_DATA), 32'(m_wd));
        chk({tag, "/data_out"}, 32'(bif.SID_DATA_OUT), 32'(m_dout));
    endtask

    task automatic idle_periods(input int n);
        int s0;
        s0 = strobe_cnt;
        for (int i = 0; i < n; i++) begin
            bus_period(1'b1, 1'b1, 5'h00, 8'h00, 1'b0);
            if (m_decay < int'(DECAY)) m_decay++;
        end
        chk("idle/strobes", 32'(strobe_cnt - s0), 32'd0);
    endtask

    task automatic chk_shadow(input string tag, input logic [4:0] a);
        @(negedge clk);
        SHD_ADDR = a;
        @(negedge clk);
        chk(tag, 32'(SHD_DATA), (a < 5'd29) ? 32'(m_shadow[a]) : 32'd0);
    endtask

    // Start a write 0x01<-0xFF and reset in the middle of its phi2-high phase.
    task automatic reset_mid_write(input string tag, input bit use_notres);
        int s0;
        s0 = strobe_cnt;
        @(negedge clk);
        bif.SID_NOTCS   = 1'b0;
        bif.SID_RW      = 1'b0;
        bif.SID_ADDR    = 5'h01;
        bif.SID_DATA_IN = 8'hFF;
        bif.SID_CLK     = 1'b1;
        repeat (3) @(negedge clk);
        if (use_notres) bif.SID_NOTRES = 1'b0;
        else            SID_RESET      = 1'b1;
        @(negedge clk);
        bif.SID_CLK = 1'b0;
        repeat (2) @(negedge clk);
        bif.SID_NOTRES = 1'b1;
        SID_RESET      = 1'b0;
        repeat (2) @(negedge clk);
        bif.SID_NOTCS = 1'b1;
        model_reset();
        chk({tag, "/strobes"}, 32'(strobe_cnt - s0), 32'd0);
        chk({tag, "/wr_addr"}, 32'(WR_ADDR), 32'd0);
        chk({tag, "/wr_data"}, 32'(WR_DATA), 32'd0);
        chk({tag, "/data_out"}, 32'(bif.SID_DATA_OUT), 32'd0);
        chk({tag, "/oe"}, 32'(bif.SID_DATA_OE), 32'd0);
        chk({tag, "/strobe_now"}, 32'(WR_STROBE), 32'd0);
        chk_shadow({tag, "/shadow1"}, 5'h01);
        chk_shadow({tag, "/shadow3"}, 5'h03);
    endtask

    initial begin
        logic [4:0] seq_addr [7];
        int         s0;
        n_cmp      = 0;
        n_err      = 0;
        strobe_cnt = 0;
        oe_cnt     = 0;
        model_reset();
        seq_addr = '{5'h18, 5'h00, 5'h01, 5'h05, 5'h06, 5'h02, 5'h04};

        SID_RESET       = 1'b1;
        bif.SID_CLK     = 1'b0;
        bif.SID_NOTRES  = 1'b1;
        bif.SID_NOTCS   = 1'b1;
        bif.SID_RW      = 1'b1;
        bif.SID_ADDR    = 5'h00;
        bif.SID_DATA_IN = 8'h00;
        POTX = 8'h00; POTY = 8'h00; OSC3 = 8'h00; ENV3 = 8'h00;
        SHD_ADDR = 5'h00;
        repeat (10) @(negedge clk);
        SID_RESET = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst/data_out", 32'(bif.SID_DATA_OUT), 32'd0);
        chk("rst/oe", 32'(bif.SID_DATA_OE), 32'd0);
        chk("rst/strobe", 32'(WR_STROBE), 32'd0);
        chk("rst/wr_addr", 32'(WR_ADDR), 32'd0);
        chk("rst/wr_data", 32'(WR_DATA), 32'd0);
        chk("rst/shd_data", 32'(SHD_DATA), 32'd0);

        // Two in-range writes, then shadow readback.
        access("t1a", 1'b0, 1'b0, 5'h18, 8'h0F, 1'b0);
        access("t1b", 1'b0, 1'b0, 5'h04, 8'h11, 1'b0);
        chk_shadow("t1/shadow04", 5'h04);
        chk_shadow("t1/shadow18", 5'h18);

        // Out-of-range write lands only in the bus latch, which then decays.
        access("t2w", 1'b0, 1'b0, 5'h1B, 8'h55, 1'b0);
        chk_shadow("t2/shadow1b", 5'h1B);
        access("t2r0", 1'b0, 1'b1, 5'h1D, 8'h00, 1'b0);
        idle_periods(int'(DECAY) - 3);
        access("t2r1", 1'b0, 1'b1, 5'h1D, 8'h00, 1'b0);
        access("t2r2", 1'b0, 1'b1, 5'h1D, 8'h00, 1'b0);
        access("t2r3", 1'b0, 1'b1, 5'h1D, 8'h00, 1'b0);

        // Live voice register read.
        OSC3 = 8'hA5;
        access("t3", 1'b0, 1'b1, 5'h1B, 8'h00, 1'b0);

        // Back-to-back writes with chip select held low.
        for (int i = 0; i < 8; i++) begin
            access($sformatf("t4_%0d", i), 1'b0, 1'b0, 5'h00, 8'(i), 1'b0);
        end
        chk_shadow("t4/shadow00", 5'h00);

        // Late RW/ADDR changes and stuck clock must not disturb anything.
        access("glitch", 1'b0, 1'b0, 5'h07, 8'h3C, 1'b1);
        chk_shadow("glitch/shadow07", 5'h07);
        s0 = strobe_cnt;
        @(negedge clk);
        bif.SID_NOTCS = 1'b0; bif.SID_RW = 1'b0; bif.SID_ADDR = 5'h08; bif.SID_DATA_IN = 8'h99;
        repeat (40) @(negedge clk);
        bif.SID_NOTCS = 1'b1;
        chk("stuck/strobes", 32'(strobe_cnt - s0), 32'd0);
        access("stuck/after", 1'b0, 1'b1, 5'h1D, 8'h00, 1'b0);

        // Resets in the middle of a write.
        POTX = 8'h3C;
        access("t5a_pre", 1'b0, 1'b1, 5'h19, 8'h00, 1'b0);
        reset_mid_write("t5a", 1'b0);
        access("t5a_latch", 1'b0, 1'b1, 5'h1D, 8'h00, 1'b0);
        access("t5b_prew", 1'b0, 1'b0, 5'h03, 8'h77, 1'b0);
        POTY = 8'hC3;
        access("t5b_prer", 1'b0, 1'b1, 5'h1A, 8'h00, 1'b0);
        reset_mid_write("t5b", 1'b1);
        access("t5b_latch", 1'b0, 1'b1, 5'h1D, 8'h00, 1'b0);

        // Initiator test sequence.
        s0 = strobe_cnt;
        for (int i = 0; i < 7; i++) begin
            access($sformatf("t6_%0d", i), 1'b0, 1'b0, seq_addr[i], 8'($urandom), 1'b0);
        end
        chk("t6/strobe_total", 32'(strobe_cnt - s0), 32'd7);

        // Random bus traffic.
        for (int i = 0; i < 60; i++) begin
            POTX = 8'($urandom); POTY = 8'($urandom);
            OSC3 = 8'($urandom); ENV3 = 8'($urandom);
            access($sformatf("rnd_%0d", i), ($urandom_range(0, 3) == 0), 1'($urandom),
                   5'($urandom), 8'($urandom), 1'($urandom));
        end

        for (int a = 0; a < 32; a++) begin
            chk_shadow($sformatf("final/shadow%02h", a), 5'(a));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
